led_pattern_ctrl: RTL and testbench

Sequencer for the 8-bit LED shift datapath on the board I/O path. It derives a step tick from the 50 MHz system clock with an internal prescaler and walks an 8-bit LED register through one of four patterns: shift right, shift left, ping-pong, or Johnson fill/empty. A start/stop handshake controls it. The block sits between the board switches/keys and the LEDR bank, and replaces the ad-hoc `counter[n]`-clocked shifters.

---
 rtl/led_pattern_ctrl.sv | 154 +++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer: prescaled step tick walks Q through shift-right/left, ping-pong or Johnson.
// Optional HOLD input and PAUSE state are built when LED_HOLD_EN is defined.
module led_pattern_ctrl #(
  parameter int unsigned DIV   = 25_000_000,
  parameter int unsigned CNT_W = 26
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] MODE,
  input  logic       START,
  input  logic       STOP,
`ifdef LED_HOLD_EN
  input  logic       HOLD,
`endif
  output logic [7:0] Q,
  output logic       BUSY,
  output logic       STEP
);

`ifdef LED_HOLD_EN
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_e;
`endif

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       mode_q, mode_in_q;
  logic             dir_q;
  logic             start_q, stop_q;
`ifdef LED_HOLD_EN
  logic             hold_q;
`endif
  logic [7:0]       pat_d;
  logic             dir_d;
  logic             wrap;

  function automatic logic [7:0] seed(input logic [1:0] m);
    case (m)
      2'b00:   seed = 8'b1000_0000;
      2'b01:   seed = 8'b0000_0001;
      2'b10:   seed = 8'b1000_0000;
      default: seed = 8'b0000_0000;
    endcase
  endfunction

  // dir_q: 0 = moving right (toward bit 0), 1 = moving left
  always_comb begin
    pat_d = Q;
    dir_d = dir_q;
    case (mode_q)
      2'b00: pat_d = {Q[0], Q[7:1]};
      2'b01: pat_d = {Q[6:0], Q[7]};
      2'b10: begin
        if (!dir_q) begin
          if (Q == 8'h01) begin
            pat_d = 8'h02;
            dir_d = 1'b1;
          end else begin
            pat_d = Q >> 1;
          end
        end else begin
          if (Q == 8'h80) begin
            pat_d = 8'h40;
            dir_d = 1'b0;
          end else begin
            pat_d = Q << 1;
          end
        end
      end
      default: pat_d = {~Q[0], Q[7:1]};
    endcase
    if (mode_q != 2'b11 && Q == 8'h00) begin
      pat_d = seed(mode_q);
      dir_d = 1'b0;
    end
  end

  assign wrap = (cnt_q == LAST);

  // Controls are registered once, so actions land one edge after sampling.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mode_q    <= 2'b00;
      mode_in_q <= 2'b00;
      dir_q     <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
`ifdef LED_HOLD_EN
      hold_q    <= 1'b0;
`endif
      Q         <= 8'h00;
      BUSY      <= 1'b0;
      STEP      <= 1'b0;
    end else begin
      start_q   <= START;
      stop_q    <= STOP;
      mode_in_q <= MODE;
`ifdef LED_HOLD_EN
      hold_q    <= HOLD;
`endif
      STEP      <= 1'b0;
      if (stop_q) begin
        state_q <= IDLE;
        Q       <= 8'h00;
        BUSY    <= 1'b0;
      end else if (start_q) begin
        state_q <= RUN;
        mode_q  <= mode_in_q;
        Q       <= seed(mode_in_q);
        cnt_q   <= '0;
        dir_q   <= 1'b0;
        BUSY    <= 1'b1;
      end else begin
        case (state_q)
`ifdef LED_HOLD_EN
          RUN, PAUSE: begin
            if (hold_q) begin
              state_q <= PAUSE;
            end else begin
              state_q <= RUN;
              if (wrap) begin
                cnt_q <= '0;
                Q     <= pat_d;
                dir_q <= dir_d;
                STEP  <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
`else
          RUN: begin
            if (wrap) begin
              cnt_q <= '0;
              Q     <= pat_d;
              dir_q <= dir_d;
              STEP  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
`endif
          default: Q <= 8'h00;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl: three instances (DIV=4,2,1) share one set of controls.
module tb_led_pattern_ctrl;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] MODE = 2'b00;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
`ifdef LED_HOLD_EN
  logic       HOLD = 1'b0;
`endif
  logic [7:0] q4, q2, q1;
  logic       b4, b2, b1, s4, s2, s1;
  int         total = 0;
  int         bad = 0;

  always #5 CLK = ~CLK;

  led_pattern_ctrl #(.DIV(4), .CNT_W(26)) u4 (
    .CLK(CLK), .RST(RST), .MODE(MODE), .START(START), .STOP(STOP),
`ifdef LED_HOLD_EN
    .HOLD(HOLD),
`endif
    .Q(q4), .BUSY(b4), .STEP(s4));
  led_pattern_ctrl #(.DIV(2), .CNT_W(26)) u2 (
    .CLK(CLK), .RST(RST), .MODE(MODE), .START(START), .STOP(STOP),
`ifdef LED_HOLD_EN
    .HOLD(1'b0),
`endif
    .Q(q2), .BUSY(b2), .STEP(s2));
  led_pattern_ctrl #(.DIV(1), .CNT_W(26)) u1 (
    .CLK(CLK), .RST(RST), .MODE(MODE), .START(START), .STOP(STOP),
`ifdef LED_HOLD_EN
    .HOLD(1'b0),
`endif
    .Q(q1), .BUSY(b1), .STEP(s1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // pulse START for one cycle; returns one edge after it was sampled (seed visible)
  task automatic go(input logic [1:0] m);
    MODE  = m;
    START = 1'b1;
    tick;
    START = 1'b0;
    tick;
  endtask

  task automatic halt;
    STOP = 1'b1;
    tick;
    STOP = 1'b0;
    tick;
  endtask

  logic [7:0] sr [8]  = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
  logic [7:0] pp [15] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02,
                          8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};
  logic [7:0] jn [16] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
                          8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};

  initial begin
    logic [7:0] prev;
    int n01, n80, n;
    #1 RST = 1'b0;
    tick;
    tick;
    chk("rst_q", q4, 8'h00);
    chk("rst_busy", b4, 1'b0);
    chk("rst_step", s4, 1'b0);
    RST = 1'b1;
    tick;

    // shift right, DIV=4
    go(2'b00);
    chk("sr_seed", q4, 8'h80);
    chk("sr_busy", b4, 1'b1);
    chk("sr_step0", s4, 1'b0);
    prev = 8'h80;
    for (int i = 0; i < 8; i++) begin
      repeat (3) tick;
      chk("sr_held", q4, prev);
      chk("sr_nostep", s4, 1'b0);
      tick;
      chk("sr_q", q4, sr[i]);
      chk("sr_step", s4, 1'b1);
      chk("sr_busyrun", b4, 1'b1);
      prev = sr[i];
    end
    halt;
    chk("stop_q", q4, 8'h00);
    chk("stop_busy", b4, 1'b0);

    // ping-pong, DIV=2
    go(2'b10);
    chk("pp_seed", q2, 8'h80);
    n01 = 0;
    n80 = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      chk("pp_nostep", s2, 1'b0);
      tick;
      chk("pp_q", q2, pp[i]);
      chk("pp_step", s2, 1'b1);
      if (i < 14 && q2 == 8'h01) n01++;
      if (i < 14 && q2 == 8'h80) n80++;
    end
    chk("pp_n01", n01, 1);
    chk("pp_n80", n80, 1);
    halt;

    // Johnson, DIV=1
    go(2'b11);
    chk("jn_seed", q1, 8'h00);
    for (int i = 0; i < 16; i++) begin
      tick;
      chk("jn_q", q1, jn[i]);
      chk("jn_step", s1, 1'b1);
    end
    halt;
    chk("jn_stop_step", s1, 1'b0);

    // shift left, mode change ignored, STOP beats START, restart
    go(2'b01);
    chk("sl_seed", q4, 8'h01);
    MODE = 2'b00;
    repeat (4) tick;
    chk("sl_q", q4, 8'h02);
    chk("sl_step", s4, 1'b1);
    START = 1'b1;
    STOP  = 1'b1;
    tick;
    START = 1'b0;
    STOP  = 1'b0;
    tick;
    chk("ss_q", q4, 8'h00);
    chk("ss_busy", b4, 1'b0);
    go(2'b00);
    chk("st_q", q4, 8'h80);
    repeat (4) tick;
    chk("st_adv", q4, 8'h40);
    go(2'b01);
    chk("restart_q", q4, 8'h01);
    chk("restart_busy", b4, 1'b1);
    halt;

    // asynchronous reset mid-sequence
    go(2'b00);
    repeat (8) tick;
    chk("pre_rst_q", q4, 8'h20);
    #2 RST = 1'b0;
    #1;
    chk("arst_q", q4, 8'h00);
    chk("arst_busy", b4, 1'b0);
    chk("arst_step", s4, 1'b0);
    tick;
    chk("arst_step2", s4, 1'b0);
    RST = 1'b1;
    tick;
    go(2'b00);
    chk("post_rst_q", q4, 8'h80);
    chk("post_rst_busy", b4, 1'b1);
    repeat (4) tick;
    chk("post_rst_adv", q4, 8'h40);
    halt;

`ifdef LED_HOLD_EN
    go(2'b00);
    repeat (4) tick;
    chk("hold_adv", q4, 8'h40);
    chk("hold_advstep", s4, 1'b1);
    tick;
    HOLD = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("hold_q", q4, 8'h40);
      chk("hold_step", s4, 1'b0);
      chk("hold_busy", b4, 1'b1);
    end
    HOLD = 1'b0;
    n = 0;
    do begin
      tick;
      n++;
    end while (!s4 && n < 20);
    chk("hold_resume", n, 3);
    chk("hold_next", q4, 8'h20);
    halt;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
